// File: rtl/lbp_frame_sequencer.sv
// Frame-level sequencer for the LBP 3x3-window datapath: raster fetch, window shift and LBP write strobes.
// Optional build macro LBP_STALL_EN lets gray_ready stall address issue during FETCH.
module lbp_frame_sequencer #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int ADDR_W = 14,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gray_ready,
    output logic              gray_req,
    output logic [ADDR_W-1:0] gray_addr,
    output logic              win_shift,
    output logic [ADDR_W-1:0] lbp_addr,
    output logic              lbp_valid,
    output logic              lbp_zero,
    output logic              finish
);

    localparam int TOTAL = IMG_W * IMG_H;
    localparam int LOG_W = $clog2(IMG_W);
    localparam logic [ADDR_W:0] TOTAL_C = (ADDR_W + 1)'(TOTAL);
    localparam logic [ADDR_W:0] WIN_C   = (ADDR_W + 1)'(IMG_W + 1);
    localparam logic [ADDR_W-LOG_W-1:0] LAST_ROW = (ADDR_W - LOG_W)'(IMG_H - 1);
    localparam logic [LOG_W-1:0]        LAST_COL = LOG_W'(IMG_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        FETCH,
        DRAIN,
        DONE
    } state_t;

    state_t              state;
    logic [ADDR_W:0]     fetch_cnt;  // next address to issue
    logic [ADDR_W:0]     data_cnt;   // pixels already shifted into the window
    logic [ADDR_W:0]     write_cnt;  // next LBP address to write
    logic [RD_LAT-1:0]   issue_pipe;
    logic                issue_ok;
    logic                emit;
    logic                border;
    logic [ADDR_W-LOG_W-1:0] row;
    logic [LOG_W-1:0]        col;

`ifdef LBP_STALL_EN
    assign issue_ok = gray_ready;
`else
    assign issue_ok = 1'b1;
`endif

    assign win_shift = issue_pipe[RD_LAT-1];
    assign row       = write_cnt[ADDR_W-1:LOG_W];
    assign col       = write_cnt[LOG_W-1:0];

    // A write is due once the window centre is valid, or unconditionally once every pixel has
    // been shifted in (the drain tail is the bottom border, which never needs real window data).
    // NOTE: every variable driven here gets a default first so no latch can be inferred.
    always_comb begin
        emit   = 1'b0;
        border = (row == '0) || (row == LAST_ROW) || (col == '0) || (col == LAST_COL);
        if ((state == FETCH || state == DRAIN) && write_cnt != TOTAL_C) begin
            emit = (win_shift && data_cnt >= WIN_C) || (data_cnt == TOTAL_C);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read in this block
    // sees the value from before the clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            fetch_cnt  <= '0;
            data_cnt   <= '0;
            write_cnt  <= '0;
            issue_pipe <= '0;
            gray_req   <= 1'b0;
            gray_addr  <= '0;
            lbp_addr   <= '0;
            lbp_valid  <= 1'b0;
            lbp_zero   <= 1'b0;
            finish     <= 1'b0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                issue_pipe[i] <= issue_pipe[i-1];
            end
            issue_pipe[0] <= gray_req;

            if (win_shift) begin
                data_cnt <= data_cnt + 1'b1;
            end

            lbp_valid <= emit;
            lbp_zero  <= emit && border;
            if (emit) begin
                lbp_addr  <= write_cnt[ADDR_W-1:0];
                write_cnt <= write_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    gray_req <= 1'b0;
                    finish   <= 1'b0;
                    state    <= WAIT_RDY;
                end
                WAIT_RDY: begin
                    if (gray_ready) begin
                        state     <= FETCH;
                        gray_req  <= 1'b1;
                        gray_addr <= '0;
                        fetch_cnt <= (ADDR_W + 1)'(1);
                    end
                end
                FETCH: begin
                    if (fetch_cnt == TOTAL_C) begin
                        gray_req <= 1'b0;
                        state    <= DRAIN;
                    end else if (issue_ok) begin
                        gray_req  <= 1'b1;
                        gray_addr <= fetch_cnt[ADDR_W-1:0];
                        fetch_cnt <= fetch_cnt + 1'b1;
                    end else begin
                        gray_req <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (write_cnt == TOTAL_C) begin
                        state  <= DONE;
                        finish <= 1'b1;
                    end
                end
                DONE: begin
                    finish <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lbp_frame_sequencer.sv
// Randomized self-checking bench for lbp_frame_sequencer (8x8 image, RD_LAT 1 and 3 instances).
// Stall scenarios run only when LBP_STALL_EN is defined.
module tb_lbp_frame_sequencer;

    localparam int W     = 8;
    localparam int H     = 8;
    localparam int AW    = 6;
    localparam int TOTAL = W * H;

    logic clk = 1'b0;
    logic reset;
    logic gray_ready;
    logic sel;

    logic          req1, shift1, valid1, zero1, fin1;
    logic [AW-1:0] gaddr1, laddr1;
    logic          req3, shift3, valid3, zero3, fin3;
    logic [AW-1:0] gaddr3, laddr3;

    logic          o_req, o_shift, o_valid, o_zero, o_fin;
    logic [AW-1:0] o_gaddr, o_laddr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lbp_frame_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .gray_ready(gray_ready),
        .gray_req(req1), .gray_addr(gaddr1), .win_shift(shift1),
        .lbp_addr(laddr1), .lbp_valid(valid1), .lbp_zero(zero1), .finish(fin1)
    );

    lbp_frame_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .gray_ready(gray_ready),
        .gray_req(req3), .gray_addr(gaddr3), .win_shift(shift3),
        .lbp_addr(laddr3), .lbp_valid(valid3), .lbp_zero(zero3), .finish(fin3)
    );

    assign o_req   = sel ? req3   : req1;
    assign o_shift = sel ? shift3 : shift1;
    assign o_valid = sel ? valid3 : valid1;
    assign o_zero  = sel ? zero3  : zero1;
    assign o_fin   = sel ? fin3   : fin1;
    assign o_gaddr = sel ? gaddr3 : gaddr1;
    assign o_laddr = sel ? laddr3 : laddr1;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int is_border(input int a);
        return ((a / W) == 0 || (a / W) == H - 1 || (a % W) == 0 || (a % W) == W - 1) ? 1 : 0;
    endfunction

    task automatic apply_reset();
        reset      = 1'b1;
        gray_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Both instances must sit silent with every output at zero while gray_ready is low.
    task automatic check_quiet(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check({tag, "_ctl1"}, {req1, valid1, shift1, zero1, fin1}, 0);
            check({tag, "_adr1"}, {gaddr1, laddr1}, 0);
            check({tag, "_ctl3"}, {req3, valid3, shift3, zero3, fin3}, 0);
        end
    endtask

    // One frame on the selected instance. stall_at<0 disables the stall, abort_at<0 disables
    // the mid-frame reset. Expectations are derived from the frame's timing rules directly.
    task automatic run_frame(input bit s, input int stall_at, input int stall_len, input int abort_at);
        int rd, cyc, c0, n_req, n_shift, n_wr, n_zero, last_wr, fin_cyc, stalling, exp_cyc, extra;
        bit stalled;
        int req_q[$];
        int shift_q[$];
        sel = s;
        rd  = s ? 3 : 1;
        cyc = 0; c0 = -1; n_req = 0; n_shift = 0; n_wr = 0; n_zero = 0;
        last_wr = -1; fin_cyc = -1; stalling = 0; stalled = 1'b0;
        repeat ($urandom_range(0, 4)) @(negedge clk);
        gray_ready = 1'b1;
        while (cyc < 400 && fin_cyc < 0) begin
            @(negedge clk);
            cyc++;
            if (o_req) begin
                check("gray_addr", o_gaddr, n_req);
                if (n_req == 0) c0 = cyc;
                req_q.push_back(cyc);
                n_req++;
            end
            if (o_shift) begin
                if (n_shift < n_req) check("shift_lat", cyc - req_q[n_shift], rd);
                else check("shift_extra", n_shift, n_req - 1);
                shift_q.push_back(cyc);
                n_shift++;
            end
            if (o_valid) begin
                if (n_wr + W + 1 < TOTAL)
                    exp_cyc = (n_wr + W + 1 < n_shift) ? shift_q[n_wr + W + 1] + 1 : -1;
                else
                    exp_cyc = last_wr + 1;
                check("lbp_addr", o_laddr, n_wr);
                check("lbp_zero", o_zero, is_border(n_wr));
                check("lbp_cycle", cyc, exp_cyc);
                if (o_zero) n_zero++;
                last_wr = cyc;
                if (n_wr == abort_at) begin
                    reset      = 1'b1;
                    gray_ready = 1'b0;
                    @(negedge clk);
                    check("abort_ctl", {o_req, o_valid, o_shift, o_zero, o_fin}, 0);
                    check("abort_adr", {o_gaddr, o_laddr}, 0);
                    return;
                end
                n_wr++;
            end
            if (o_fin) fin_cyc = cyc;
            if (stall_at >= 0 && !stalled && o_req && o_gaddr == stall_at[AW-1:0]) begin
                gray_ready = 1'b0;
                stalling   = stall_len;
                stalled    = 1'b1;
            end else if (stalling > 0) begin
                stalling--;
                if (stalling == 0) gray_ready = 1'b1;
            end
        end
        extra = (stall_at >= 0) ? stall_len : 0;
        check("finish_seen", (fin_cyc >= 0) ? 1 : 0, 1);
        check("req_count", n_req, TOTAL);
        check("shift_count", n_shift, TOTAL);
        check("write_count", n_wr, TOTAL);
        check("border_count", n_zero, 2 * W + 2 * (H - 2));
        check("finish_latency", fin_cyc - c0, TOTAL + rd + W + 2 + extra);
        check("finish_after_last", fin_cyc, last_wr + 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("done_hold", {o_fin, o_valid, o_req, o_shift}, 4'b1000);
        end
    endtask

    initial begin
        sel        = 1'b0;
        reset      = 1'b1;
        gray_ready = 1'b0;

        // Reset then a long gray_ready-low wait: nothing may move.
        apply_reset();
        check_quiet("wait_rdy", 20);

        // Full frames on the RD_LAT=1 and RD_LAT=3 instances.
        run_frame(1'b0, -1, 0, -1);
        apply_reset();
        run_frame(1'b1, -1, 0, -1);

`ifdef LBP_STALL_EN
        apply_reset();
        run_frame(1'b0, 20, 5, -1);
        apply_reset();
        run_frame(1'b1, int'($urandom_range(1, 60)), int'($urandom_range(1, 9)), -1);
`endif

        // Mid-frame reset, then the design must come back silent and run a clean frame.
        apply_reset();
        run_frame(1'b0, -1, 0, 30);
        @(negedge clk);
        reset = 1'b0;
        check_quiet("post_abort", 5);
        run_frame(1'b0, -1, 0, -1);

        // Random-instance frame with a random mid-frame abort point and a follow-up frame.
        apply_reset();
        run_frame(1'($urandom_range(0, 1)), -1, 0, int'($urandom_range(0, TOTAL - 1)));
        @(negedge clk);
        reset = 1'b0;
        check_quiet("post_abort2", 3);
        run_frame(1'($urandom_range(0, 1)), -1, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
